uart_tx: RTL

UART transmitter that serialises bytes onto a single line, one bit per full period of the baud clock `TxC` from the baud-rate generator. Each upstream byte becomes a frame: start bit, LSB-first data, optional parity, then stop bit(s). A one-entry holding register lets the next byte be accepted while the current frame shifts, so back-to-back frames have no idle gap. The block sits directly downstream of the baud-rate generator and drives the chip's TxD pin.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_tick_gen.sv | 27 ++
 rtl/uart_tx.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions.
// Holds the transmitter FSM encoding and the baud timing constants used by the
// baud-rate generator, transmitter and receiver.
package uart_pkg;

    // Transmitter frame sequencer states.
    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } uart_tx_state_e;

    // Terminal count of the baud-rate generator: TxC toggles every 218 clocks.
    localparam logic [7:0]  BAUD_DIV = 8'd217;

    // One full TxC period, i.e. the length of one serial bit in clk cycles.
    localparam int unsigned BIT_CLKS = 436;

endpackage

// File: rtl/uart_tick_gen.sv
// Rising-edge detector for the baud clock.
// Ports:
//   clk    - system clock
//   resetn - asynchronous active-low reset
//   txc    - baud clock, already registered in the clk domain
//   tick   - one-cycle pulse on the first clk cycle TxC is seen high after low
module uart_tick_gen (
    input  logic clk,
    input  logic resetn,
    input  logic txc,
    output logic tick
);

    logic txc_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            txc_q <= 1'b0;
        end else begin
            txc_q <= txc;
        end
    end

    // txc is a registered source, so no synchroniser is needed here.
    assign tick = txc & ~txc_q;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter.
// Serialises bytes as start bit, LSB-first data, optional parity and stop bit(s),
// one bit per TxC period. A one-entry holding register accepts the next byte
// while the current frame shifts so consecutive frames run without idle gaps.
// Ports:
//   clk      - system clock
//   resetn   - asynchronous active-low reset
//   TxC      - baud clock from the baud-rate generator
//   tx_data  - byte to send, sampled only on accept
//   tx_valid - tx_data is valid
//   tx_ready - holding register empty; accept on tx_valid & tx_ready
//   TxD      - serial line, idle high
//   busy     - frame in progress or byte waiting in the holding register
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 TxC,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 TxD,
    output logic                 busy
);

    localparam logic       ParityEn  = (PARITY_EN != 0);
    localparam logic       ParityOdd = (PARITY_ODD != 0);
    localparam logic [2:0] LastData  = 3'(DATA_BITS - 1);
    localparam logic [2:0] LastStop  = 3'(STOP_BITS - 1);

    logic                 tick;
    uart_tx_state_e       state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] hold_data_q, hold_data_d;
    logic                 hold_full_q, hold_full_d;
    logic [2:0]           cnt_q, cnt_d;
    logic                 parity_q, parity_d;
    logic                 txd_q, txd_d;
    logic                 load;

    uart_tick_gen u_tick_gen (
        .clk    (clk),
        .resetn (resetn),
        .txc    (TxC),
        .tick   (tick)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= StIdle;
            shift_q     <= '0;
            hold_data_q <= '0;
            hold_full_q <= 1'b0;
            cnt_q       <= 3'd0;
            parity_q    <= 1'b0;
            txd_q       <= 1'b1;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            hold_data_q <= hold_data_d;
            hold_full_q <= hold_full_d;
            cnt_q       <= cnt_d;
            parity_q    <= parity_d;
            txd_q       <= txd_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        hold_data_d = hold_data_q;
        hold_full_d = hold_full_q;
        cnt_d       = cnt_q;
        parity_d    = parity_q;
        txd_d       = txd_q;
        load        = 1'b0;

        // Accept only into an empty holder; a transfer needs a full one, so the
        // two can never collide in the same cycle.
        if (tx_valid && !hold_full_q) begin
            hold_full_d = 1'b1;
            hold_data_d = tx_data;
        end

        if (tick) begin
            unique case (state_q)
                StIdle: begin
                    if (hold_full_q) begin
                        load = 1'b1;
                    end
                end
                StStart: begin
                    state_d = StData;
                    txd_d   = shift_q[0];
                    cnt_d   = 3'd0;
                end
                StData: begin
                    shift_d = shift_q >> 1;
                    if (cnt_q == LastData) begin
                        cnt_d = 3'd0;
                        if (ParityEn) begin
                            state_d = StParity;
                            txd_d   = parity_q;
                        end else begin
                            state_d = StStop;
                            txd_d   = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                        txd_d = shift_q[1];
                    end
                end
                StParity: begin
                    state_d = StStop;
                    txd_d   = 1'b1;
                    cnt_d   = 3'd0;
                end
                StStop: begin
                    if (cnt_q == LastStop) begin
                        cnt_d = 3'd0;
                        // A queued byte starts on this very tick: no idle bit.
                        if (hold_full_q) begin
                            load = 1'b1;
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
                default: begin
                    state_d = StIdle;
                    txd_d   = 1'b1;
                end
            endcase
        end

        if (load) begin
            shift_d     = hold_data_q;
            // Parity is fixed at load so it does not depend on the shifted copy.
            parity_d    = (^hold_data_q) ^ ParityOdd;
            hold_full_d = 1'b0;
            state_d     = StStart;
            txd_d       = 1'b0;
        end
    end

    assign tx_ready = ~hold_full_q;
    assign TxD      = txd_q;
    assign busy     = (state_q != StIdle) | hold_full_q;

endmodule
